rotate_sdram_arbiter: RTL
=========================

Name: rotate_sdram_arbiter

Overview:
- Shares one SDRAM client port between the rotation core's two streams: the input write stream (vidin_*, 8-word bursts) and the output read stream (vidout_*, 8-word bursts).
- Maps (frame, x, y) to a tiled word address, so that an 8-word row run or an 8-word column run stays inside one SDRAM row.
- Sequences each burst word by word, paces writes to suit the core's registered data path, and arbitrates round-robin at burst boundaries.

Parameters:
- HCNT_WIDTH, 10, width of the x/y coordinates.
- ADDR_WIDTH, 24, SDRAM word-address width; must be at least 2*HCNT_WIDTH+2.
- BASE_ADDR, 0, word offset added to every generated address.
- WR_GAP, 2, idle cycles after each write-word acknowledge before the next word is sampled; range 1..7.

Ports:
- clk_sys in 1: system clock.
- reset_n in 1: asynchronous active-low reset.
- vidin_req in 1: write burst pending.
- vidin_frame in 2: write frame.
- vidin_x in HCNT_WIDTH: write x coordinate.
- vidin_y in HCNT_WIDTH: write y coordinate.
- vidin_d in 16: write data.
- vidin_ack out 1: one-cycle pulse per write word consumed.
- vidout_req in 1: read stream active.
- vidout_frame in 2: read frame.
- vidout_x in HCNT_WIDTH: read x coordinate.
- vidout_y in HCNT_WIDTH: read y coordinate.
- vidout_d out 16: read data.
- vidout_ack out 1: one-cycle pulse per valid read word.
- ram_req out 1: word request (writes) or burst request (reads).
- ram_we out 1: 1 = write.
- ram_addr out ADDR_WIDTH: word address.
- ram_wdata out 16: write data.
- ram_ack in 1: controller accepted the request. Writes: one ack per word. Reads: one ack for the whole burst.
- ram_rvalid in 1: read word valid.
- ram_rdata in 16: read word.

Behaviour:
- Address = BASE_ADDR + {frame, y[H-1:3], x[H-1:3], y[2:0], x[2:0]}, zero-extended to ADDR_WIDTH. Wrap-around modulo 2^ADDR_WIDTH is allowed.
- Reset values:
  - state IDLE; all outputs 0.
  - last_grant = WRITE, so the first tie is won by the read stream.
- States: IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_DATA.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the stream not served last (round-robin); update last_grant on each grant.
  - Write grant: register addr and data from vidin_* and go to WR_ISSUE on the next cycle.
  - Read grant: register addr from vidout_* with x[2:0] forced to 0, set word count 0, go to RD_ISSUE.
- WR_ISSUE:
  - ram_req=1, ram_we=1; addr and data held stable.
  - On ram_ack: vidin_ack=1 on the following cycle (registered), word count +1, go to WR_GAP.
- WR_GAP:
  - ram_req=0 for WR_GAP cycles.
  - On the last gap cycle, re-sample vidin_x/y/d into the address and data registers.
  - After the 8th word, return to IDLE instead of re-sampling.
- RD_ISSUE:
  - ram_req=1, ram_we=0.
  - On ram_ack: go to RD_DATA; ram_req falls the cycle after ack.
- RD_DATA:
  - Each ram_rvalid gives vidout_d<=ram_rdata and vidout_ack=1 on the next cycle; count +1.
  - After the 8th valid word, go to IDLE.
  - ram_rvalid outside RD_DATA is ignored.
- A granted burst always completes 8 words. Deasserting the request mid-burst does not abort or shorten it.
- A request held high after burst completion is re-arbitrated in IDLE, so a continuous vidout_req is served one 8-word burst at a time.
- Minimum idle between bursts is 1 cycle (in IDLE).
- Simultaneous ram_ack and ram_rvalid in RD_ISSUE: treat as ack followed by the first data word (count=1).
- Starvation bound: with both requests held, grants strictly alternate W/R.
- Reset asserted mid-burst: return immediately to IDLE with outputs 0. A partial burst is abandoned and the SDRAM controller must also be reset.
- vidout_frame and vidout_x/y are sampled only at grant; changes during the burst are ignored.
- vidin_* are sampled only at grant and at the end of each gap.

Test Plan:
1. Write only: vidin_req with frame=1, x=16, y=3, d=0xA5A5, and ram_ack one cycle after each ram_req.
   - ram_addr = BASE + {2'b01, 7'd0, 7'd2, 3'd3, 3'd0}.
   - 8 vidin_ack pulses, spaced at least WR_GAP+2 cycles apart.
   - ram_req low in every gap.
   - Returns to IDLE.
2. Read only: vidout_req with x=40, y=5, ram_ack after 3 cycles, then 8 ram_rvalid with data 0..7.
   - ram_addr has x[2:0]=0.
   - ram_we=0.
   - 8 vidout_ack pulses with vidout_d=0..7 in order.
3. Contention: both requests held high from reset for 4 bursts.
   - Grant order R, W, R, W.
   - No burst interleaving.
4. vidout_req drops after the 1st valid word.
   - Remaining 7 words are still delivered with vidout_ack.
   - No new read grant follows.
5. Column write with the core varying vidin_y[2:0]=0..7 per word and fixed x=9.
   - Consecutive addresses differ by 8.
   - All 8 addresses lie within one 64-word tile.
6. reset_n pulsed low in WR_GAP after word 3.
   - All outputs 0 immediately (asynchronously).
   - State IDLE.
   - Next vidin_req restarts at word 0.

Source files
------------

// File: rtl/rotate_sdram_arbiter.sv
// Shares one SDRAM client port between the rotation write and read streams.
// Tiled addressing keeps 8-word row or column runs inside one SDRAM row.
module rotate_sdram_arbiter #(
  parameter int HCNT_WIDTH = 10,
  parameter int ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WR_GAP = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  vidin_req,
  input  logic [1:0]            vidin_frame,
  input  logic [HCNT_WIDTH-1:0] vidin_x,
  input  logic [HCNT_WIDTH-1:0] vidin_y,
  input  logic [15:0]           vidin_d,
  output logic                  vidin_ack,
  input  logic                  vidout_req,
  input  logic [1:0]            vidout_frame,
  input  logic [HCNT_WIDTH-1:0] vidout_x,
  input  logic [HCNT_WIDTH-1:0] vidout_y,
  output logic [15:0]           vidout_d,
  output logic                  vidout_ack,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  input  logic                  ram_ack,
  input  logic                  ram_rvalid,
  input  logic [15:0]           ram_rdata
);

  localparam int H  = HCNT_WIDTH;
  localparam int TW = 2 * H + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_GAP,
    S_RD_ISSUE,
    S_RD_DATA
  } state_t;

  state_t state, state_nxt;

  logic         last_wr;
  logic         wr_grant;
  logic         rd_grant;
  logic         rd_take;
  logic         gap_last;
  logic         burst_done;
  logic [1:0]   frame;
  logic [3:0]   cnt;
  logic [2:0]   gap;
  logic [H-1:0] rd_x;

  function automatic logic [ADDR_WIDTH-1:0] tile(
    input logic [1:0]   f,
    input logic [H-1:0] x,
    input logic [H-1:0] y
  );
    logic [TW-1:0] t;
    t = {f, y[H-1:3], x[H-1:3], y[2:0], x[2:0]};
    return BASE_ADDR + ADDR_WIDTH'(t);
  endfunction

  assign rd_x       = {vidout_x[H-1:3], 3'b000};
  assign gap_last   = (gap == 3'(WR_GAP - 1));
  assign burst_done = (cnt == 4'd8);

  // An ack coinciding with rvalid already carries the first read word
  assign rd_take = ram_rvalid &&
                   ((state == S_RD_DATA) ||
                    (state == S_RD_ISSUE && ram_ack));

  always_comb begin
    state_nxt = state;
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (vidin_req && (!vidout_req || !last_wr)) begin
          wr_grant  = 1'b1;
          state_nxt = S_WR_ISSUE;
        end else if (vidout_req) begin
          rd_grant  = 1'b1;
          state_nxt = S_RD_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        ram_req = 1'b1;
        ram_we  = 1'b1;
        if (ram_ack) state_nxt = S_WR_GAP;
      end
      S_WR_GAP: begin
        if (gap_last)
          state_nxt = burst_done ? S_IDLE : S_WR_ISSUE;
      end
      S_RD_ISSUE: begin
        ram_req = 1'b1;
        if (ram_ack) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (rd_take && cnt == 4'd7) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_wr    <= 1'b1;
      frame      <= '0;
      cnt        <= '0;
      gap        <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      vidin_ack  <= 1'b0;
      vidout_ack <= 1'b0;
      vidout_d   <= '0;
    end else begin
      state      <= state_nxt;
      vidin_ack  <= 1'b0;
      vidout_ack <= 1'b0;
      if (wr_grant) begin
        ram_addr  <= tile(vidin_frame, vidin_x, vidin_y);
        ram_wdata <= vidin_d;
        frame     <= vidin_frame;
        cnt       <= '0;
        last_wr   <= 1'b1;
      end
      if (rd_grant) begin
        ram_addr <= tile(vidout_frame, rd_x, vidout_y);
        cnt      <= '0;
        last_wr  <= 1'b0;
      end
      if (state == S_WR_ISSUE && ram_ack) begin
        vidin_ack <= 1'b1;
        cnt       <= cnt + 4'd1;
        gap       <= '0;
      end
      if (state == S_WR_GAP) begin
        gap <= gap + 3'd1;
        // The core updates x/y/d during the gap; take them on its last cycle
        if (gap_last && !burst_done) begin
          ram_addr  <= tile(frame, vidin_x, vidin_y);
          ram_wdata <= vidin_d;
        end
      end
      if (rd_take) begin
        vidout_d   <= ram_rdata;
        vidout_ack <= 1'b1;
        cnt        <= cnt + 4'd1;
      end
    end
  end

endmodule
